// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle between the ALU sequencer and the digit-serial adder.
interface digit_serial_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (output start, sub, cin, a, b,
                  input  busy, done, sum, cout, ovf, zero);
  modport slave  (input  start, sub, cin, a, b,
                  output busy, done, sum, cout, ovf, zero);
endinterface

// File: rtl/digit_adder.sv
// Combinational ripple of full-adder cells for one digit; also exposes the carry into the digit MSB.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic       cc;
  logic [1:0] fa;

  always_comb begin
    s    = '0;
    cmsb = 1'b0;
    cc   = ci;
    fa   = 2'b00;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = cc;
      fa   = full_add(a[i], b[i], cc);
      s[i] = fa[0];
      cc   = fa[1];
    end
    co = cc;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_adder_if.slave  bus
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  adder_state_t         state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     sa;
  logic [WIDTH-1:0]     sb;
  logic [WIDTH-1:0]     sr;
  logic                 carry;
  logic [WIDTH-1:0]     sum_q;
  logic                 cout_q;
  logic                 ovf_q;
  logic                 zero_q;

  logic [DIGIT-1:0]     dsum;
  logic                 dco;
  logic                 dcm;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]     sr_next;
  logic                 last;
  logic                 capture;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (sa[DIGIT-1:0]),
    .b    (sb[DIGIT-1:0]),
    .ci   (carry),
    .s    (dsum),
    .co   (dco),
    .cmsb (dcm)
  );

  // Digits enter the result register from the top, so after N shifts it is aligned.
  assign cat     = {dsum, sr};
  assign sr_next = WIDTH'(cat >> DIGIT);
  assign last    = (cnt == CW'(N - 1));
  assign capture = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (capture) begin
            sa    <= bus.a;
            sb    <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> DIGIT;
          sb    <= sb >> DIGIT;
          sr    <= sr_next;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= sr_next;
            cout_q <= dco;
            ovf_q  <= dcm ^ dco;
            zero_q <= (sr_next == '0);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule
